// File: rtl/data_mem_unit_pkg.sv
// Shared constants for the MEM-stage data memory: funct3 width codes,
// control-word bit positions and the alignment rule used by stores and loads.
package data_mem_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Positions of mem-read / mem-write inside the 32-bit EX/MEM control word
    localparam int CTRL_MEM_READ_BIT  = 3;
    localparam int CTRL_MEM_WRITE_BIT = 4;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_ram.sv
// Byte-write, synchronous-read data RAM with CPU/debug address mux.
// The read register is shared: debug dumps and CPU loads never overlap in time.
module data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_rd_en,
    input  logic                    i_dbg_en,
    input  logic [ADDR_W-1:0]       i_cpu_addr,
    input  logic [ADDR_W-1:0]       i_dbg_addr,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_W-1:0]     addr;

    assign addr = i_dbg_en ? i_dbg_addr : i_cpu_addr;

    // Array kept free of reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we[b]) begin
                mem_q[addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_dbg_en || i_rd_en) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage load/store unit: byte-enable generation, alignment check,
// load side registers and combinational extraction on the registered RAM word.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [2:0]                i_funct3,
    input  logic [DATA_WIDTH-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic                      i_dbg_en,
    input  logic [MEM_DEPTH_LOG2-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic [DATA_WIDTH-1:0]     o_dbg_rdata,
    output logic                      o_misalign
);

    localparam int NB = DATA_WIDTH / 8;

    logic [MEM_DEPTH_LOG2-1:0] word_idx;
    logic [1:0]                offset;
    logic                      cpu_act;
    logic                      misalign_now;
    logic [NB-1:0]             we;
    logic [DATA_WIDTH-1:0]     wdata_lanes;
    logic [DATA_WIDTH-1:0]     ram_word;
    logic                      unused_addr;

    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                offset_q, offset_d;
    logic                      misalign_q, misalign_d;

    assign word_idx     = i_addr[MEM_DEPTH_LOG2+1:2];
    assign offset       = i_addr[1:0];
    assign unused_addr  = ^i_addr[DATA_WIDTH-1:MEM_DEPTH_LOG2+2];
    assign cpu_act      = i_en & ~i_dbg_en;
    assign misalign_now = is_misaligned(i_funct3, offset);

    always_comb begin
        we          = '0;
        wdata_lanes = i_wdata;
        if (i_mem_write && cpu_act && !i_rst && !misalign_now) begin
            case (i_funct3)
                F3_B: begin
                    we          = NB'(1) << offset;
                    wdata_lanes = {NB{i_wdata[7:0]}};
                end
                F3_H: begin
                    we          = offset[1] ? NB'(4'b1100) : NB'(4'b0011);
                    wdata_lanes = {(NB/2){i_wdata[15:0]}};
                end
                F3_W:    we = '1;
                default: we = '0;
            endcase
        end
    end

    data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_rd_en    (i_en & i_mem_read),
        .i_dbg_en   (i_dbg_en),
        .i_cpu_addr (word_idx),
        .i_dbg_addr (i_dbg_addr),
        .i_we       (we),
        .i_wdata    (wdata_lanes),
        .o_rdata    (ram_word)
    );

    always_comb begin
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        misalign_d = cpu_act & (i_mem_read | i_mem_write) & misalign_now;
        if (i_en && i_mem_read) begin
            funct3_d = i_funct3;
            offset_d = offset;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            funct3_q   <= '0;
            offset_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            misalign_q <= misalign_d;
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = ram_word[8*offset_q +: 8];
        sel_half = offset_q[1] ? ram_word[31:16] : ram_word[15:0];
        o_rdata  = '0;
        // Misaligned loads return zero rather than a rotated word
        if (!is_misaligned(funct3_q, offset_q)) begin
            case (funct3_q)
                F3_B:    o_rdata = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
                F3_BU:   o_rdata = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                F3_H:    o_rdata = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
                F3_HU:   o_rdata = {{(DATA_WIDTH-16){1'b0}}, sel_half};
                F3_W:    o_rdata = ram_word;
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_dbg_rdata = ram_word;
    assign o_misalign  = misalign_q;

endmodule
